// File: rtl/priority_index_bcd.sv
// Debounced priority encoder for the switch bank with a sequential
// double-dabble BCD converter feeding the seven-segment drivers.
//
// Ports:
//   CLOCK_50_I       system clock, rising edge
//   RESETN_I         asynchronous active-low reset
//   SWITCH_I         raw request inputs (asynchronous)
//   PRIORITY_MODE_I  0: highest index wins, 1: lowest index wins (asynchronous)
//   INDEX_O          1-based winning index, 0 when nothing is asserted
//   BCD_O            BCD of INDEX_O, digit 0 in [3:0], blanked digits read 4'hF
//   NONE_O           no input asserted
//   UPDATE_O         one-cycle pulse when INDEX_O/BCD_O/NONE_O take new values
//   BUSY_O           encode/convert pass in progress
module priority_index_bcd #(
    parameter int unsigned NUM_IN         = 18,
    parameter int unsigned NUM_DIGITS     = 2,
    parameter int unsigned SAMPLE_DIV     = 50000,
    parameter int unsigned STABLE_SAMPLES = 4,
    parameter int unsigned BLANK_LEADING  = 1,
    localparam int unsigned IDX_W         = $clog2(NUM_IN + 1),
    localparam int unsigned BCD_W         = 4 * NUM_DIGITS
) (
    input  logic              CLOCK_50_I,
    input  logic              RESETN_I,
    input  logic [NUM_IN-1:0] SWITCH_I,
    input  logic              PRIORITY_MODE_I,
    output logic [IDX_W-1:0]  INDEX_O,
    output logic [BCD_W-1:0]  BCD_O,
    output logic              NONE_O,
    output logic              UPDATE_O,
    output logic              BUSY_O
);

    localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned STB_W = $clog2(STABLE_SAMPLES + 1);
    localparam int unsigned CNT_W = $clog2(IDX_W + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [STB_W-1:0] STB_MAX  = STB_W'(STABLE_SAMPLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDX_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENCODE  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // Input synchronisers
    logic [NUM_IN-1:0] sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic              mode_s1_q, mode_s1_d, mode_s2_q, mode_s2_d;

    // Debounce
    logic [DIV_W-1:0]  div_q, div_d;
    logic [NUM_IN-1:0] sample_q, sample_d;
    logic [STB_W-1:0]  stable_q, stable_d;
    logic [NUM_IN-1:0] acc_q, acc_d;

    // Conversion FSM and datapath
    state_e            state_q, state_d;
    logic              pending_q, pending_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  idx_sh_q, idx_sh_d;
    logic [BCD_W-1:0]  bcd_sh_q, bcd_sh_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Registered outputs
    logic [IDX_W-1:0]  index_q, index_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              none_q, none_d;
    logic              update_q, update_d;
    logic              busy_q, busy_d;

    logic              tick_c, accept_c, mode_chg_c, req_c, lead_c;
    logic [IDX_W-1:0]  enc_c;
    logic [BCD_W-1:0]  dabble_c, blank_c;

    // Two-flop synchronisers; a change on the synced mode is seen one cycle before it lands
    always_comb begin
        sw_s1_d    = SWITCH_I;
        sw_s2_d    = sw_s1_q;
        mode_s1_d  = PRIORITY_MODE_I;
        mode_s2_d  = mode_s1_q;
        mode_chg_c = (mode_s1_q != mode_s2_q);
    end

    // Sample divider, stability counter and accepted-vector update
    always_comb begin
        div_d    = div_q;
        sample_d = sample_q;
        stable_d = stable_q;
        acc_d    = acc_q;
        accept_c = 1'b0;
        tick_c   = (div_q == DIV_LAST);
        if (tick_c) begin
            div_d    = '0;
            sample_d = sw_s2_q;
            if (sw_s2_q == sample_q) begin
                if (stable_q != STB_MAX) begin
                    stable_d = stable_q + STB_W'(1);
                end
            end else begin
                stable_d = STB_W'(1);
            end
            if ((stable_d == STB_MAX) && (sw_s2_q != acc_q)) begin
                acc_d    = sw_s2_q;
                accept_c = 1'b1;
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Priority encoder: the last hit in scan order wins
    always_comb begin
        enc_c = '0;
        if (mode_s2_q) begin
            for (int i = int'(NUM_IN) - 1; i >= 0; i--) begin
                if (acc_q[i]) enc_c = IDX_W'(i + 1);
            end
        end else begin
            for (int i = 0; i < int'(NUM_IN); i++) begin
                if (acc_q[i]) enc_c = IDX_W'(i + 1);
            end
        end
    end

    // Double-dabble correction: +3 on every nibble >= 5 before the shift
    always_comb begin
        dabble_c = bcd_sh_q;
        for (int d = 0; d < int'(NUM_DIGITS); d++) begin
            if (bcd_sh_q[4*d +: 4] >= 4'd5) begin
                dabble_c[4*d +: 4] = bcd_sh_q[4*d +: 4] + 4'd3;
            end
        end
    end

    // Display formatting: all-blank for no index, optional leading-zero blanking
    always_comb begin
        blank_c = bcd_sh_q;
        lead_c  = 1'b1;
        if (idx_q == '0) begin
            blank_c = {BCD_W{1'b1}};
        end else if (BLANK_LEADING != 0) begin
            for (int d = int'(NUM_DIGITS) - 1; d > 0; d--) begin
                if (lead_c && (bcd_sh_q[4*d +: 4] == 4'd0)) begin
                    blank_c[4*d +: 4] = 4'hF;
                end else begin
                    lead_c = 1'b0;
                end
            end
        end
    end

    // Conversion FSM: next state, datapath and output loads
    always_comb begin
        req_c     = accept_c | mode_chg_c;
        state_d   = state_q;
        pending_d = pending_q;
        idx_d     = idx_q;
        idx_sh_d  = idx_sh_q;
        bcd_sh_d  = bcd_sh_q;
        cnt_d     = cnt_q;
        index_d   = index_q;
        bcd_d     = bcd_q;
        none_d    = none_q;
        update_d  = 1'b0;

        // Requests during a pass collapse into a single follow-up pass
        if ((state_q != ST_IDLE) && req_c) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_c || pending_q) begin
                    state_d   = ST_ENCODE;
                    pending_d = 1'b0;
                end
            end
            ST_ENCODE: begin
                idx_d    = enc_c;
                idx_sh_d = enc_c;
                bcd_sh_d = '0;
                cnt_d    = '0;
                state_d  = ST_CONVERT;
            end
            ST_CONVERT: begin
                bcd_sh_d = {dabble_c[BCD_W-2:0], idx_sh_q[IDX_W-1]};
                idx_sh_d = idx_sh_q << 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                index_d  = idx_q;
                bcd_d    = blank_c;
                none_d   = (idx_q == '0);
                update_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State register
    always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            mode_s1_q <= 1'b0;
            mode_s2_q <= 1'b0;
            div_q     <= '0;
            sample_q  <= '0;
            stable_q  <= '0;
            acc_q     <= '0;
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            idx_q     <= '0;
            idx_sh_q  <= '0;
            bcd_sh_q  <= '0;
            cnt_q     <= '0;
            index_q   <= '0;
            bcd_q     <= {BCD_W{1'b1}};
            none_q    <= 1'b1;
            update_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sw_s1_q   <= sw_s1_d;
            sw_s2_q   <= sw_s2_d;
            mode_s1_q <= mode_s1_d;
            mode_s2_q <= mode_s2_d;
            div_q     <= div_d;
            sample_q  <= sample_d;
            stable_q  <= stable_d;
            acc_q     <= acc_d;
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            idx_sh_q  <= idx_sh_d;
            bcd_sh_q  <= bcd_sh_d;
            cnt_q     <= cnt_d;
            index_q   <= index_d;
            bcd_q     <= bcd_d;
            none_q    <= none_d;
            update_q  <= update_d;
            busy_q    <= busy_d;
        end
    end

    assign INDEX_O  = index_q;
    assign BCD_O    = bcd_q;
    assign NONE_O   = none_q;
    assign UPDATE_O = update_q;
    assign BUSY_O   = busy_q;

endmodule

// File: tb/tb_priority_index_bcd.sv
// Self-checking bench for priority_index_bcd: a constant vector table,
// hand-timed multi-cycle sequences, random vectors against an arithmetic
// reference model, and a wide (100-input, 3-digit) instance.
module tb_priority_index_bcd;

    logic        clk;
    logic        rst_n;
    logic [17:0] sw;
    logic        mode;
    logic [4:0]  idx;
    logic [7:0]  bcd;
    logic        none, upd, busy;

    logic [99:0] sw2;
    logic        mode2;
    logic [6:0]  idx2;
    logic [11:0] bcd2;
    logic        none2, upd2, busy2;

    int n_cmp;
    int n_bad;
    int cyc;

    priority_index_bcd #(
        .NUM_IN(18), .NUM_DIGITS(2), .SAMPLE_DIV(4), .STABLE_SAMPLES(3), .BLANK_LEADING(1)
    ) dut (
        .CLOCK_50_I(clk), .RESETN_I(rst_n), .SWITCH_I(sw), .PRIORITY_MODE_I(mode),
        .INDEX_O(idx), .BCD_O(bcd), .NONE_O(none), .UPDATE_O(upd), .BUSY_O(busy)
    );

    priority_index_bcd #(
        .NUM_IN(100), .NUM_DIGITS(3), .SAMPLE_DIV(4), .STABLE_SAMPLES(3), .BLANK_LEADING(1)
    ) dut_wide (
        .CLOCK_50_I(clk), .RESETN_I(rst_n), .SWITCH_I(sw2), .PRIORITY_MODE_I(mode2),
        .INDEX_O(idx2), .BCD_O(bcd2), .NONE_O(none2), .UPDATE_O(upd2), .BUSY_O(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge count since reset release; sample ticks land on edges where cyc % 4 == 0
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        logic [17:0] sw;
        logic        mode;
        logic [4:0]  idx;
        logic [7:0]  bcd;
        logic        none;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Highest set bit -> clog2(v+1); lowest set bit isolated with v & -v
    function automatic int ref_index(input logic [17:0] v, input logic m);
        int x;
        x = int'({14'b0, v});
        if (x == 0) return 0;
        if (!m) return $clog2(x + 1);
        return $clog2(x & -x) + 1;
    endfunction

    function automatic logic [31:0] ref_bcd(input int value, input int nd);
        logic [31:0] r;
        int v;
        r = '0;
        if (value == 0) begin
            for (int d = 0; d < nd; d++) r[4*d +: 4] = 4'hF;
            return r;
        end
        v = value;
        for (int d = 0; d < nd; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        for (int d = 1; d < nd; d++) begin
            if (value < 10 ** d) r[4*d +: 4] = 4'hF;
        end
        return r;
    endfunction

    // Step n falling edges, counting UPDATE pulses of the selected instance
    task automatic run_watch(input int n, input bit wide, inout int pulses, inout int first);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if ((wide ? upd2 : upd) === 1'b1) begin
                if (first < 0) first = cyc;
                pulses++;
            end
        end
    endtask

    // Align to the falling edge right after a sample tick
    task automatic wait_tick(output int k);
        bit found;
        found = 1'b0;
        k = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (cyc > 0 && (cyc % 4) == 0) begin
                found = 1'b1;
                k = cyc;
            end
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_tick: no sample tick within 8 cycles (cyc=%0d)", cyc);
        end
    endtask

    task automatic check_outs(input string name, input int e_idx, input logic [7:0] e_bcd, input logic e_none);
        check({name, " index"}, 32'(idx), 32'(e_idx));
        check({name, " bcd"},   32'(bcd), 32'(e_bcd));
        check({name, " none"},  32'(none), 32'(e_none));
        check({name, " busy"},  32'(busy), 32'd0);
    endtask

    initial begin
        int k, p, f;
        int e_idx;
        logic [31:0] e_bcd;

        tbl[0]  = '{18'h3FFFF, 1'b0, 5'd18, 8'h18, 1'b0};
        tbl[1]  = '{18'h3FFFF, 1'b1, 5'd1,  8'hF1, 1'b0};
        tbl[2]  = '{18'h00200, 1'b0, 5'd10, 8'h10, 1'b0};
        tbl[3]  = '{18'h00400, 1'b1, 5'd11, 8'h11, 1'b0};
        tbl[4]  = '{18'h00100, 1'b0, 5'd9,  8'hF9, 1'b0};
        tbl[5]  = '{18'h00000, 1'b0, 5'd0,  8'hFF, 1'b1};
        tbl[6]  = '{18'h0A000, 1'b0, 5'd16, 8'h16, 1'b0};
        tbl[7]  = '{18'h0A000, 1'b1, 5'd14, 8'h14, 1'b0};
        tbl[8]  = '{18'h00C30, 1'b1, 5'd5,  8'hF5, 1'b0};
        tbl[9]  = '{18'h00C30, 1'b0, 5'd12, 8'h12, 1'b0};
        tbl[10] = '{18'h20000, 1'b1, 5'd18, 8'h18, 1'b0};
        tbl[11] = '{18'h00001, 1'b0, 5'd1,  8'hF1, 1'b0};

        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        sw    = '0;
        mode  = 1'b0;
        sw2   = '0;
        mode2 = 1'b0;

        // Reset values, then quiet release with all switches low
        repeat (2) @(negedge clk);
        check("rst update", 32'(upd), 32'd0);
        check_outs("rst", 0, 8'hFF, 1'b1);
        rst_n = 1'b1;
        p = 0; f = -1;
        run_watch(40, 1'b0, p, f);
        check("quiet release pulses", 32'(p), 32'd0);
        check_outs("quiet release", 0, 8'hFF, 1'b1);
        check("wide idle index", 32'(idx2), 32'd0);
        check("wide idle bcd", 32'(bcd2), 32'hFFF);

        // Highest then lowest of two asserted inputs
        sw = 18'h20001;
        p = 0; f = -1;
        run_watch(40, 1'b0, p, f);
        check("hi pulses", 32'(p), 32'd1);
        check_outs("hi", 18, 8'h18, 1'b0);
        mode = 1'b1;
        p = 0; f = -1;
        run_watch(20, 1'b0, p, f);
        check("lo pulses", 32'(p), 32'd1);
        check_outs("lo", 1, 8'hF1, 1'b0);

        // Table of vectors
        for (int i = 0; i < 12; i++) begin
            sw   = tbl[i].sw;
            mode = tbl[i].mode;
            repeat (50) @(negedge clk);
            check_outs($sformatf("tbl%0d", i), int'(tbl[i].idx), tbl[i].bcd, tbl[i].none);
        end

        // Bouncing bit 5: no acceptance until it holds, then exactly one update
        sw = '0;
        mode = 1'b0;
        repeat (50) @(negedge clk);
        wait_tick(k);
        p = 0; f = -1;
        for (int t = 0; t < 5; t++) begin
            sw = (t % 2 == 0) ? 18'h00020 : 18'h00000;
            run_watch(4, 1'b0, p, f);
        end
        run_watch(40, 1'b0, p, f);
        check("bounce pulses", 32'(p), 32'd1);
        check_outs("bounce", 6, 8'hF6, 1'b0);

        // Vector accepted mid-pass: pass on the mode change, then a pending pass
        wait_tick(k);
        sw = 18'h00200;
        p = 0; f = -1;
        run_watch(7, 1'b0, p, f);
        mode = 1'b1;
        run_watch(5, 1'b0, p, f);
        check("busy at accept", 32'(busy), 32'd1);
        run_watch(40, 1'b0, p, f);
        check("busy pulses", 32'(p), 32'd2);
        check("busy first update edge", 32'(f - k), 32'd16);
        check_outs("busy", 10, 8'h10, 1'b0);

        // Reset during CONVERT aborts the pass immediately
        mode = 1'b0;
        p = 0; f = -1;
        run_watch(4, 1'b0, p, f);
        check("pre-abort busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        sw = '0;
        #1;
        check("abort update", 32'(upd), 32'd0);
        check_outs("abort", 0, 8'hFF, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_watch(40, 1'b0, p, f);
        check("abort pulses", 32'(p), 32'd0);
        check_outs("after abort", 0, 8'hFF, 1'b1);

        // Random vectors against the reference model
        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 3))
                0:       sw = '0;
                1:       sw = 18'(1) << $urandom_range(0, 17);
                default: sw = 18'($urandom);
            endcase
            mode = 1'($urandom_range(0, 1));
            repeat (50) @(negedge clk);
            e_idx = ref_index(sw, mode);
            e_bcd = ref_bcd(e_idx, 2);
            check_outs($sformatf("rand%0d sw=%05h m=%0d", i, sw, mode), e_idx, e_bcd[7:0], e_idx == 0);
        end

        // Wide instance: index 100, three digits, latency of IDX_W+2 = 9 edges
        wait_tick(k);
        sw2 = '0;
        sw2[99] = 1'b1;
        p = 0; f = -1;
        run_watch(40, 1'b1, p, f);
        check("wide pulses", 32'(p), 32'd1);
        check("wide latency", 32'(f - k), 32'd21);
        check("wide index", 32'(idx2), 32'd100);
        check("wide bcd", 32'(bcd2), 32'h100);
        check("wide none", 32'(none2), 32'd0);
        check("wide busy", 32'(busy2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
